// File: rtl/adc_ltc2308_ctrl_pkg.sv
// Shared types and constants for the LTC2308 conversion controller.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Config word bit positions (word is sent MSB first)
  localparam int CFG_SD  = 5;
  localparam int CFG_OS  = 4;
  localparam int CFG_S1  = 3;
  localparam int CFG_S0  = 2;
  localparam int CFG_UNI = 1;
  localparam int CFG_SLP = 0;

  localparam int ADC_DATA_W = 12;
  localparam int ADC_CFG_W  = 6;
  // One SCK period per result bit, two refclk phases per SCK period
  localparam int SHIFT_LEN  = 2 * ADC_DATA_W;

  // Single-ended, unipolar, no sleep; channel bits scattered as the ADC expects
  function automatic logic [ADC_CFG_W-1:0] build_cfg(input logic [2:0] ch);
    logic [ADC_CFG_W-1:0] cfg;
    cfg          = '0;
    cfg[CFG_SD]  = 1'b1;
    cfg[CFG_OS]  = ch[0];
    cfg[CFG_S1]  = ch[2];
    cfg[CFG_S0]  = ch[1];
    cfg[CFG_UNI] = 1'b1;
    cfg[CFG_SLP] = 1'b0;
    return cfg;
  endfunction

endpackage

// File: rtl/adc_ltc2308_ctrl_if.sv
// Host-side request/result bundle for the LTC2308 controller.
interface adc_ltc2308_ctrl_if #(
  parameter int DATA_W = 12
);
  logic              start;
  logic [2:0]        channel;
  logic              busy;
  logic              data_valid;
  logic [DATA_W-1:0] data;
  logic [2:0]        data_ch;

  modport master (
    output start, channel,
    input  busy, data_valid, data, data_ch
  );

  modport slave (
    input  start, channel,
    output busy, data_valid, data, data_ch
  );
endinterface

// File: rtl/adc_ltc2308_ctrl.sv
// LTC2308 conversion controller: CONVST pulse, conversion wait, then a
// 12-bit full-duplex shift (config out on SDI, previous result in on SDO).
module adc_ltc2308_ctrl
  import adc_pkg::*;
#(
  parameter int DATA_W      = ADC_DATA_W,
  parameter int CFG_W       = ADC_CFG_W,
  parameter int CONV_CYCLES = 2
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               locked,
  adc_ltc2308_ctrl_if.slave  host,
  output logic               adc_convst,
  output logic               adc_sck,
  output logic               adc_sdi,
  input  logic               adc_sdo
);

  localparam int SHIFT_N = 2 * DATA_W;
  localparam int PH_W    = $clog2(SHIFT_N);
  localparam int CONV_W  = $clog2(CONV_CYCLES + 2);

  state_t              state;
  logic [PH_W-1:0]     phase;
  logic [CONV_W-1:0]   conv_cnt;
  logic [CFG_W-1:0]    cfg_sr;
  logic [DATA_W-1:0]   sr;
  logic [2:0]          ch_q;
  logic [2:0]          prev_ch;
  logic                first_frame;

  // Single FSM; every ADC pin and host output is a register
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      phase           <= '0;
      conv_cnt        <= '0;
      cfg_sr          <= '0;
      sr              <= '0;
      ch_q            <= '0;
      prev_ch         <= '0;
      first_frame     <= 1'b1;
      adc_convst      <= 1'b0;
      adc_sck         <= 1'b0;
      adc_sdi         <= 1'b0;
      host.busy       <= 1'b0;
      host.data_valid <= 1'b0;
      host.data       <= '0;
      host.data_ch    <= '0;
    end else begin
      host.data_valid <= 1'b0;
      if (state != IDLE && !locked) begin
        // Lost PLL lock: drop the frame; the ADC's next result is untrusted
        state       <= IDLE;
        adc_convst  <= 1'b0;
        adc_sck     <= 1'b0;
        adc_sdi     <= 1'b0;
        host.busy   <= 1'b0;
        first_frame <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (host.start && locked) begin
              ch_q       <= host.channel;
              cfg_sr     <= CFG_W'(build_cfg(host.channel));
              conv_cnt   <= '0;
              adc_convst <= 1'b1;
              host.busy  <= 1'b1;
              state      <= CONV;
            end
          end
          CONV: begin
            adc_convst <= 1'b0;
            if (conv_cnt == CONV_W'(CONV_CYCLES)) begin
              // First SDI bit is set up half an SCK period before the rise
              state   <= SHIFT;
              phase   <= '0;
              adc_sdi <= cfg_sr[CFG_W-1];
              cfg_sr  <= cfg_sr << 1;
            end else begin
              conv_cnt <= conv_cnt + 1'b1;
            end
          end
          SHIFT: begin
            // SDO is sampled at the end of each low half of SCK
            if (!phase[0]) sr <= {sr[DATA_W-2:0], adc_sdo};
            if (phase == PH_W'(SHIFT_N - 1)) begin
              state   <= DONE;
              adc_sck <= 1'b0;
              adc_sdi <= 1'b0;
              // ADC returns the previous conversion, so tag with prev_ch
              if (!first_frame) begin
                host.data       <= sr;
                host.data_ch    <= prev_ch;
                host.data_valid <= 1'b1;
              end
              first_frame <= 1'b0;
              prev_ch     <= ch_q;
            end else begin
              phase   <= phase + 1'b1;
              adc_sck <= ~phase[0];
              // Advance SDI only on falling SCK; drained cfg_sr yields zeros
              if (phase[0]) begin
                adc_sdi <= cfg_sr[CFG_W-1];
                cfg_sr  <= cfg_sr << 1;
              end
            end
          end
          DONE: begin
            host.busy <= 1'b0;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_ltc2308_ctrl.sv
// Directed bench for adc_ltc2308_ctrl with a simple LTC2308 SDO model.
module tb_adc_ltc2308_ctrl;

  logic        refclk = 1'b0;
  logic        rst;
  logic        locked;
  logic        adc_convst, adc_sck, adc_sdi, adc_sdo;
  logic [11:0] adc_word;
  logic [3:0]  k = 4'd0;
  int          n_tests = 0;
  int          n_fail  = 0;

  adc_ltc2308_ctrl_if #(.DATA_W(12)) host ();

  adc_ltc2308_ctrl #(.DATA_W(12), .CFG_W(6), .CONV_CYCLES(2)) dut (
    .refclk     (refclk),
    .rst        (rst),
    .locked     (locked),
    .host       (host.slave),
    .adc_convst (adc_convst),
    .adc_sck    (adc_sck),
    .adc_sdi    (adc_sdi),
    .adc_sdo    (adc_sdo)
  );

  always #5 refclk = ~refclk;

  // ADC model: B11 presented after CONVST, next bit after each SCK rise
  always @(posedge adc_convst or posedge adc_sck) begin
    if (adc_convst) k = 4'd0;
    else if (k < 4'd12) k = k + 4'd1;
  end
  assign adc_sdo = (k < 4'd12) ? adc_word[4'd11 - k] : 1'b0;

  // One conversion from IDLE; optional lock drop or reset at cycle i
  task automatic do_frame(input string nm, input logic [2:0] ch, input logic [5:0] cfg,
                          input logic [11:0] word, input bit expv,
                          input logic [11:0] exp_d, input logic [2:0] exp_c,
                          input int abort_at, input int rst_at);
    int  e_cv = 0, e_sck = 0, e_sdi = 0, e_busy = 0, e_val = 0;
    int  p;
    bit  cut = 0;
    logic ex_cv, ex_sck, ex_sdi, ex_val;
    adc_word     = word;
    host.channel = ch;
    host.start   = 1'b1;
    for (int i = 1; i <= 28 && !cut; i++) begin
      @(negedge refclk);
      if (i == 1) host.start = 1'b0;
      p      = i - 4;
      ex_cv  = (i == 1);
      ex_sck = (i >= 4 && i <= 27) ? (p % 2 == 1) : 1'b0;
      ex_sdi = (i >= 4 && p < 12) ? cfg[5 - p/2] : 1'b0;
      ex_val = expv && (i == 28);
      if (adc_convst !== ex_cv) e_cv++;
      if (adc_sck !== ex_sck) e_sck++;
      if (adc_sdi !== ex_sdi) e_sdi++;
      if (host.busy !== 1'b1) e_busy++;
      if (host.data_valid !== ex_val) e_val++;
      if (i == abort_at) begin
        locked = 1'b0;
        cut = 1;
      end
      if (i == rst_at) begin
        #1 rst = 1'b1;
        #1;
        n_tests++;
        if ({host.busy, host.data_valid, host.data, host.data_ch, adc_convst, adc_sck, adc_sdi} !== 20'h0) begin
          n_fail++;
          $display("FAIL %s async_reset: outputs=%h required 0", nm,
                   {host.busy, host.data_valid, host.data, host.data_ch, adc_convst, adc_sck, adc_sdi});
        end
        cut = 1;
      end
    end
    n_tests++; if (e_cv != 0)   begin n_fail++; $display("FAIL %s convst: %0d bad cycles, required 0", nm, e_cv); end
    n_tests++; if (e_sck != 0)  begin n_fail++; $display("FAIL %s sck: %0d bad cycles, required 0", nm, e_sck); end
    n_tests++; if (e_sdi != 0)  begin n_fail++; $display("FAIL %s sdi: %0d bad cycles, required 0", nm, e_sdi); end
    n_tests++; if (e_busy != 0) begin n_fail++; $display("FAIL %s busy: %0d low cycles, required 0", nm, e_busy); end
    n_tests++; if (e_val != 0)  begin n_fail++; $display("FAIL %s data_valid: %0d bad cycles, required 0", nm, e_val); end
    if (abort_at != 0) begin
      @(negedge refclk);
      n_tests++;
      if ({host.busy, host.data_valid, adc_convst, adc_sck, adc_sdi} !== 5'b0) begin
        n_fail++;
        $display("FAIL %s abort_idle: busy/valid/convst/sck/sdi=%b required 00000", nm,
                 {host.busy, host.data_valid, adc_convst, adc_sck, adc_sdi});
      end
      locked = 1'b1;
    end else if (rst_at != 0) begin
      @(negedge refclk);
      rst = 1'b0;
    end else begin
      @(negedge refclk);
      n_tests++;
      if (host.busy !== 1'b0 || host.data_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s end_idle: busy=%b valid=%b required 0 0", nm, host.busy, host.data_valid);
      end
    end
    n_tests++;
    if (host.data !== exp_d || host.data_ch !== exp_c) begin
      n_fail++;
      $display("FAIL %s result: data=%h ch=%0d required data=%h ch=%0d", nm, host.data, host.data_ch, exp_d, exp_c);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; locked = 1'b0; host.start = 1'b0; host.channel = 3'd0; adc_word = 12'h0;
    repeat (2) @(negedge refclk);
    n_tests++;
    if ({host.busy, host.data_valid, host.data, host.data_ch, adc_convst, adc_sck, adc_sdi} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset: outputs=%h required 0",
               {host.busy, host.data_valid, host.data, host.data_ch, adc_convst, adc_sck, adc_sdi});
    end
    rst = 1'b0;
    @(negedge refclk);
  endtask

  task automatic test_no_lock();
    int hits = 0;
    locked = 1'b0; host.channel = 3'd2; host.start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge refclk);
      if (adc_convst !== 1'b0 || host.busy !== 1'b0) hits++;
    end
    host.start = 1'b0;
    n_tests++;
    if (hits != 0) begin
      n_fail++;
      $display("FAIL no_lock: %0d active cycles, required 0", hits);
    end
    locked = 1'b1;
    @(negedge refclk);
  endtask

  task automatic test_back_to_back();
    int accepts = 0, idles = 0, valids = 0, badpos = 0;
    adc_word = 12'h3C7; host.channel = 3'd6; host.start = 1'b1;
    for (int t = 1; t <= 87; t++) begin
      @(negedge refclk);
      if (adc_convst === 1'b1) begin
        accepts++;
        if (t != 1 && t != 30 && t != 59) badpos++;
      end
      if (host.busy !== 1'b1) idles++;
      if (host.data_valid === 1'b1) valids++;
    end
    host.start = 1'b0;
    n_tests++; if (accepts != 3) begin n_fail++; $display("FAIL b2b accepts: %0d required 3", accepts); end
    n_tests++; if (badpos != 0)  begin n_fail++; $display("FAIL b2b spacing: %0d off-grid pulses required 0", badpos); end
    n_tests++; if (idles != 3)   begin n_fail++; $display("FAIL b2b idle_cycles: %0d required 3", idles); end
    n_tests++; if (valids != 3)  begin n_fail++; $display("FAIL b2b valids: %0d required 3", valids); end
    n_tests++;
    if (host.data !== 12'h3C7 || host.data_ch !== 3'd6) begin
      n_fail++;
      $display("FAIL b2b result: data=%h ch=%0d required data=3c7 ch=6", host.data, host.data_ch);
    end
  endtask

  initial begin
    test_reset();
    test_no_lock();
    do_frame("first_frame", 3'd3, 6'b110110, 12'h123, 1'b0, 12'h000, 3'd0, 0, 0);
    do_frame("second_frame", 3'd5, 6'b111010, 12'hA5C, 1'b1, 12'hA5C, 3'd3, 0, 0);
    test_back_to_back();
    do_frame("lock_abort", 3'd1, 6'b110010, 12'hFFF, 1'b0, 12'h3C7, 3'd6, 14, 0);
    do_frame("post_abort", 3'd2, 6'b100110, 12'h0F0, 1'b0, 12'h3C7, 3'd6, 0, 0);
    do_frame("recovered", 3'd4, 6'b101010, 12'h5A1, 1'b1, 12'h5A1, 3'd2, 0, 0);
    do_frame("rst_mid", 3'd7, 6'b111110, 12'h777, 1'b0, 12'h000, 3'd0, 0, 10);
    do_frame("post_rst", 3'd0, 6'b100010, 12'h321, 1'b0, 12'h000, 3'd0, 0, 0);
    do_frame("after_rst", 3'd3, 6'b110110, 12'h9E4, 1'b1, 12'h9E4, 3'd0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
